contador_multi: RTL and testbench
=================================

# contador_multi

Parametrised per-channel word counter for the output stage. It counts pops from `FIFO_UNITS` output FIFOs plus one aggregate pop stream. When the datapath is idle, it returns any channel's count through a registered request/valid handshake. Over the earlier fixed 4-channel counter it adds:

- configurable counter width
- a wrap or saturate mode
- sticky per-channel overflow flags
- optional clear-on-read
- a synchronous global clear

## Interface

Parameters:

- `FIFO_UNITS`, 4: number of counted channels (1..2^INDEX).
- `INDEX`, 2: width of `idx`; must satisfy 2^INDEX >= FIFO_UNITS.
- `CNT_W`, 5: width of each per-channel counter.
- `TOT_W`, 8: width of the aggregate counter.
- `SATURATE`, 0: 0 means counters wrap at all-ones; 1 means counters hold at all-ones.
- `CLEAR_ON_READ`, 0: 1 means an accepted request zeroes the addressed channel counter and its overflow flag.

Ports (one clock; reset is asynchronous and active-high):

- `clk` input 1: clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `pop` input FIFO_UNITS: per-channel pop strobes; bit i increments counter i.
- `pop_total` input 1: aggregate pop strobe; increments the total counter.
- `IDLE` input 1: high when all FIFOs are empty; requests are only accepted while it is high.
- `req` input 1: count request.
- `idx` input INDEX: channel addressed by `req`.
- `clear` input 1: synchronous clear of all counters and flags.
- `cuenta` output CNT_W: registered count of the requested channel.
- `total` output TOT_W: registered aggregate count.
- `valid` output 1: one-cycle-per-accept response strobe.
- `ovf` output FIFO_UNITS: sticky overflow flags, one per channel.

## Operation

Reset (asynchronous, immediate):

- all counters, the total counter and `ovf` go to 0.
- `cuenta`, `total` and `valid` go to 0.

Counting:

- Each cycle with `pop[i]`=1, counter i increments by 1.
- Each cycle with `pop_total`=1, the total counter increments by 1.
- All channels count independently; simultaneous pops on every channel are all counted in the same cycle.

Overflow:

- An increment of a counter already at all-ones sets its `ovf[i]`.
- With `SATURATE`=0 the counter wraps to 0; with `SATURATE`=1 it stays at all-ones.
- The total counter follows the same wrap/saturate rule but has no flag.

Clear:

- `clear`=1 zeroes all counters, the total counter and `ovf` at the edge.
- `clear` overrides any pops in the same cycle; those pops are lost.

Request accept:

- A request is accepted when `req`=1 and `IDLE`=1 at the edge. Otherwise `req` is ignored; it is not queued.
- On accept, the next cycle shows `valid`=1, `cuenta` equal to counter[idx], and `total` equal to the total counter.
- The values captured are those before that edge's increments.
- If `idx` >= `FIFO_UNITS`, the response has `valid`=1 and `cuenta`=0.

Non-accept cycles:

- `valid`=0 and `cuenta`=0.
- `total` also drops to 0; outputs are zero when not valid.

Clear-on-read (`CLEAR_ON_READ`=1):

- The accepted channel's counter and `ovf` bit zero at the accept edge.
- A `pop` on that same channel at that edge leaves the counter at 1 (clear applied, then increment).

Priority at one edge: `reset` > `clear` > clear-on-read > increment.

Response state machine:

- States: `S_IDLE` (`valid`=0) and `S_RESP` (`valid`=1).
- `S_IDLE` goes to `S_RESP` on accept.
- `S_RESP` stays in `S_RESP` on another accept (back-to-back responses) and returns to `S_IDLE` otherwise.
- `clear` in the same cycle as an accept: the response shows the pre-clear values.

## Timing

- Request to `valid`: 1 cycle latency. Throughput is one request per cycle.
- Pop to visible count: a pop at edge N is reflected in responses to requests accepted at edge N+1 or later.
- `IDLE` falling while in `S_RESP`: the pending response still completes; no new accepts.
- `reset` asserted mid-response: `valid` drops immediately (asynchronously).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Basic count.** After reset, pulse `pop[2]` for 7 cycles, then `IDLE`=1, `req`=1, `idx`=2 for one cycle -> the next cycle shows `valid`=1, `cuenta`=7; the following cycle shows `valid`=0, `cuenta`=0.
- **Gated request.** With `IDLE`=0, hold `req`=1 -> `valid` stays 0. Raise `IDLE` -> `valid` rises exactly 1 cycle later.
- **Wrap vs. saturate (`CNT_W`=5).**
  - `SATURATE`=0, 33 pops on channel 0 -> `cuenta`=1, `ovf[0]`=1.
  - `SATURATE`=1, same stimulus -> `cuenta`=31, `ovf[0]`=1.
- **Clear-on-read (`CLEAR_ON_READ`=1).** 5 pops on channel 1, request 1 -> `cuenta`=5. Request again while `pop[1]` is high at the first accept edge -> `cuenta`=1.
- **Back-to-back multi-channel.** Pop counts 3/0/9/4 on channels 0..3 with 16 `pop_total`, then request `idx`=0,1,2,3 on consecutive cycles -> `valid` high for 4 cycles, `cuenta`=3,0,9,4 in order, `total`=16 throughout.
- **Clear and reset priority.**
  - `clear` with simultaneous `pop[0]` -> counter 0 reads 0.
  - `reset` pulsed mid-stream between edges -> all outputs 0 immediately, counts restart from 0.

Source files
------------

// File: rtl/contador_multi.sv
// Per-channel pop counter with wrap/saturate, sticky overflow flags, optional
// clear-on-read and a registered request/valid readout gated by IDLE.
`timescale 1ns/1ps
module contador_multi #(
  parameter int FIFO_UNITS    = 4,
  parameter int INDEX         = 2,
  parameter int CNT_W         = 5,
  parameter int TOT_W         = 8,
  parameter int SATURATE      = 0,
  parameter int CLEAR_ON_READ = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FIFO_UNITS-1:0] pop,
  input  logic                  pop_total,
  input  logic                  IDLE,
  input  logic                  req,
  input  logic [INDEX-1:0]      idx,
  input  logic                  clear,
  output logic [CNT_W-1:0]      cuenta,
  output logic [TOT_W-1:0]      total,
  output logic                  valid,
  output logic [FIFO_UNITS-1:0] ovf
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q [FIFO_UNITS];
  logic [CNT_W-1:0]      cnt_d [FIFO_UNITS];
  logic [FIFO_UNITS-1:0] ovf_q, ovf_d;
  logic [TOT_W-1:0]      tot_q, tot_d;
  logic [CNT_W-1:0]      sel_cnt;
  logic [CNT_W-1:0]      cuenta_q;
  logic [TOT_W-1:0]      total_q;
  logic                  accept;

  assign accept = req & IDLE;

  // Out-of-range idx matches no channel and therefore reads back as zero.
  always_comb begin : sel_mux
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_cnt = '0;
    for (int i = 0; i < FIFO_UNITS; i++) begin
      if (idx == INDEX'(i)) sel_cnt = cnt_q[i];
    end
  end

  // Per-channel next state: clear-on-read first, then the increment, so a pop
  // on the channel being read lands on a zeroed counter.
  always_comb begin : count_next
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < FIFO_UNITS; i++) begin
      if (CLEAR_ON_READ != 0 && accept && idx == INDEX'(i)) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end
      if (pop[i]) begin
        if (&cnt_d[i]) begin
          ovf_d[i] = 1'b1;
          if (SATURATE == 0) cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_d[i] + CNT_W'(1);
        end
      end
    end
    if (clear) begin
      for (int i = 0; i < FIFO_UNITS; i++) cnt_d[i] = '0;
      ovf_d = '0;
    end
  end

  always_comb begin : total_next
    tot_d = tot_q;
    if (pop_total) begin
      if (!(&tot_q))          tot_d = tot_q + TOT_W'(1);
      else if (SATURATE == 0) tot_d = '0;
    end
    if (clear) tot_d = '0;
  end

  // NOTE: the counter array is reset explicitly because a read right after reset must return 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_UNITS; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
      tot_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      tot_q <= tot_d;
    end
  end

  // Response capture uses pre-edge counts, so clear or pops at the accept edge are not visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta_q <= '0;
      total_q  <= '0;
    end else begin
      cuenta_q <= accept ? sel_cnt : '0;
      total_q  <= accept ? tot_q   : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RESP;
      S_RESP:  state_d = accept ? S_RESP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : fsm_out
    valid  = (state_q == S_RESP);
    cuenta = cuenta_q;
    total  = total_q;
    ovf    = ovf_q;
  end

endmodule

// File: tb/tb_contador_multi.sv
// Directed bench: dut0 uses defaults (wrap, no clear-on-read, 4 channels);
// dut1 shares the stimulus with 3 channels, saturation and clear-on-read.
`timescale 1ns/1ps
module tb_contador_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pop;
  logic       pop_total, idle, req, clear;
  logic [1:0] idx;
  logic [4:0] cuenta0, cuenta1;
  logic [7:0] total0, total1;
  logic       valid0, valid1;
  logic [3:0] ovf0;
  logic [2:0] ovf1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  contador_multi dut0 (
    .clk(clk), .reset(reset), .pop(pop), .pop_total(pop_total), .IDLE(idle),
    .req(req), .idx(idx), .clear(clear), .cuenta(cuenta0), .total(total0),
    .valid(valid0), .ovf(ovf0)
  );

  contador_multi #(.FIFO_UNITS(3), .INDEX(2), .CNT_W(5), .TOT_W(8),
                   .SATURATE(1), .CLEAR_ON_READ(1)) dut1 (
    .clk(clk), .reset(reset), .pop(pop[2:0]), .pop_total(pop_total), .IDLE(idle),
    .req(req), .idx(idx), .clear(clear), .cuenta(cuenta1), .total(total1),
    .valid(valid1), .ovf(ovf1)
  );

  typedef struct {
    logic [3:0] pop;
    logic       pt;
    logic       idle;
    logic       req;
    logic [1:0] idx;
    logic       clr;
    logic       ev;
    logic [4:0] ec0;
    logic [4:0] ec1;
    logic [7:0] et;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] p, input logic pt, input logic i_idle,
                       input logic r, input logic [1:0] ix, input logic c);
    pop = p; pop_total = pt; idle = i_idle; req = r; idx = ix; clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    pop = '0; pop_total = 0; idle = 0; req = 0; idx = '0; clear = 0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 5'd3, 5'd3, 8'd16};
    tbl[1]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 5'd0, 5'd0, 8'd16};
    tbl[2]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 5'd9, 5'd9, 8'd16};
    tbl[3]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 5'd4, 5'd0, 8'd16};
    tbl[4]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0, 8'd0};
    tbl[5]  = '{4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 5'd3, 5'd0, 8'd16};
    tbl[6]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 5'd4, 5'd1, 8'd16};
    tbl[7]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 5'd9, 5'd0, 8'd16};
    tbl[8]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 5'd0, 5'd0, 8'd0};
    tbl[9]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 5'd0, 8'd0};
    tbl[10] = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 5'd0, 5'd0, 8'd0};
    tbl[11] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0, 8'd0};
    tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0, 8'd0};
    tbl[13] = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 5'd0, 5'd0, 8'd1};
    tbl[14] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0, 5'd0, 8'd0};

    // Reset state
    reset = 1'b1;
    pop = '0; pop_total = 0; idle = 0; req = 0; idx = '0; clear = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid0", valid0, 0);
    check("reset cuenta0", cuenta0, 0);
    check("reset total0", total0, 0);
    check("reset ovf0", ovf0, 0);
    check("reset valid1", valid1, 0);
    reset = 1'b0;

    // Basic count: 7 pops on channel 2, then one request
    repeat (7) drive(4'b0100, 0, 0, 0, 2'd0, 0);
    drive(4'b0000, 0, 1, 1, 2'd2, 0);
    check("basic valid", valid0, 1);
    check("basic cuenta0", cuenta0, 7);
    check("basic cuenta1", cuenta1, 7);
    drive(4'b0000, 0, 1, 0, 2'd2, 0);
    check("basic after valid", valid0, 0);
    check("basic after cuenta", cuenta0, 0);

    // Gated request: held while IDLE is low, accepted once it rises
    for (int k = 0; k < 3; k++) begin
      drive(4'b0000, 0, 0, 1, 2'd2, 0);
      check($sformatf("gated valid%0d", k), valid0, 0);
    end
    drive(4'b0000, 0, 1, 1, 2'd2, 0);
    check("gated rise valid", valid0, 1);
    check("gated cuenta0", cuenta0, 7);
    check("gated cor cuenta1", cuenta1, 0);
    drive(4'b0000, 0, 1, 0, 2'd2, 0);
    check("gated fall valid", valid0, 0);

    // Multi-channel load: 3/0/9/4 pops with 16 total pops
    pulse_reset();
    for (int c = 0; c < 16; c++)
      drive({c < 4, c < 9, 1'b0, c < 3}, 1, 0, 0, 2'd0, 0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].pop, tbl[i].pt, tbl[i].idle, tbl[i].req, tbl[i].idx, tbl[i].clr);
      check($sformatf("vec%0d valid0", i), valid0, tbl[i].ev);
      check($sformatf("vec%0d valid1", i), valid1, tbl[i].ev);
      check($sformatf("vec%0d cuenta0", i), cuenta0, tbl[i].ec0);
      check($sformatf("vec%0d cuenta1", i), cuenta1, tbl[i].ec1);
      check($sformatf("vec%0d total0", i), total0, tbl[i].et);
      check($sformatf("vec%0d total1", i), total1, tbl[i].et);
    end

    // Wrap vs saturate: 33 pops on channel 0, 257 total pops
    pulse_reset();
    for (int c = 0; c < 257; c++) begin
      drive({3'b000, c < 33}, 1, 0, 0, 2'd0, 0);
      if (c == 30) check("ovf0 at 31 pops", ovf0, 4'b0000);
      if (c == 31) begin
        check("ovf0 at 32 pops", ovf0, 4'b0001);
        check("ovf1 at 32 pops", ovf1, 3'b001);
      end
    end
    check("ovf0 sticky", ovf0, 4'b0001);
    check("ovf1 sticky", ovf1, 3'b001);
    drive(4'b0000, 0, 1, 1, 2'd0, 0);
    check("wrap cuenta0", cuenta0, 1);
    check("sat cuenta1", cuenta1, 31);
    check("wrap total0", total0, 1);
    check("sat total1", total1, 255);
    check("ovf0 after read", ovf0, 4'b0001);
    check("ovf1 cleared by read", ovf1, 3'b000);

    // Asynchronous reset in the middle of a response
    check("pre-reset valid", valid0, 1);
    #3 reset = 1'b1;
    #1;
    check("async valid0", valid0, 0);
    check("async valid1", valid1, 0);
    check("async cuenta1", cuenta1, 0);
    check("async total1", total1, 0);
    check("async ovf0", ovf0, 0);
    pop = '0; pop_total = 0; idle = 0; req = 0; idx = '0; clear = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) drive(4'b0010, 0, 0, 0, 2'd0, 0);
    drive(4'b0000, 0, 1, 1, 2'd1, 0);
    check("restart cuenta0", cuenta0, 2);
    check("restart cuenta1", cuenta1, 2);
    check("restart total0", total0, 0);
    drive(4'b0000, 0, 0, 0, 2'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
